rank_filter_3x3: RTL and testbench

RANK_FILTER_3X3 -- requirements
Module: rank_filter_3x3

---
 rtl/rank_filter_3x3.sv | 230 +++++++++++++++++++++++
 tb/tb_rank_filter_3x3.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rank_filter_3x3.sv
// 3x3 rank-order filter (bypass / median / min / max) over a streamed raster, fixed 5-cycle latency.
// Define RANK_FILTER_STATS_EN to add the per-frame changed_cnt output.
module rank_filter_3x3 #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned LINE_MAX = 1024,
    parameter logic [1:0]  MODE_RST = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        filter_mode,
    input  logic              per_img_vsync,
    input  logic              per_img_href,
    input  logic              per_img_de,
    input  logic [DATA_W-1:0] per_img_gray,
    output logic              post_img_vsync,
    output logic              post_img_href,
    output logic              post_img_de,
    output logic [DATA_W-1:0] post_img_gray,
`ifdef RANK_FILTER_STATS_EN
    output logic [31:0]       changed_cnt,
`endif
    output logic [1:0]        mode_active
);

    localparam int unsigned         COL_W    = $clog2(LINE_MAX);
    localparam int unsigned         ROW_W    = 12;
    localparam logic [COL_W-1:0]    COL_LAST = COL_W'(LINE_MAX - 1);

    typedef logic [DATA_W-1:0] pix_t;

    function automatic pix_t min2(pix_t a, pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t max2(pix_t a, pix_t b);
        return (a < b) ? b : a;
    endfunction

    function automatic pix_t min3(pix_t a, pix_t b, pix_t c);
        return min2(min2(a, b), c);
    endfunction

    function automatic pix_t max3(pix_t a, pix_t b, pix_t c);
        return max2(max2(a, b), c);
    endfunction

    function automatic pix_t med3(pix_t a, pix_t b, pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // ---------------------------------------------------------------- counters
    logic             vsync_q, href_q;
    logic             vs_rise, href_fall;
    logic [COL_W-1:0] col_q;
    logic             ovf_q;
    logic [ROW_W-1:0] row_q;
    logic             lb_we;
    logic             win_full;

    assign vs_rise   = per_img_vsync & ~vsync_q;
    assign href_fall = ~per_img_href & href_q;
    assign lb_we     = per_img_de & ~ovf_q;
    assign win_full  = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2)) && !ovf_q;

    // col saturates at the last buffer slot; ovf_q marks pixels beyond the buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            col_q       <= '0;
            ovf_q       <= 1'b0;
            row_q       <= '0;
            mode_active <= MODE_RST;
        end else begin
            vsync_q <= per_img_vsync;
            href_q  <= per_img_href;
            if (vs_rise) begin
                mode_active <= filter_mode;
            end
            if (href_fall) begin
                col_q <= '0;
                ovf_q <= 1'b0;
            end else if (per_img_de) begin
                if (col_q == COL_LAST) begin
                    ovf_q <= 1'b1;
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
            if (vs_rise) begin
                row_q <= '0;
            end else if (href_fall && row_q != '1) begin
                row_q <= row_q + ROW_W'(1);
            end
        end
    end

    // ------------------------------------------------------------ line buffers
    pix_t lb1_mem [LINE_MAX];
    pix_t lb2_mem [LINE_MAX];
    pix_t lb1_rd, lb2_rd;

    assign lb1_rd = lb1_mem[col_q];
    assign lb2_rd = lb2_mem[col_q];

    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb1_mem[col_q] <= per_img_gray;
            lb2_mem[col_q] <= lb1_rd;
        end
    end

    // -------------------------------------------------------------- strobes
    logic [2:0] strb_q [5];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                strb_q[i] <= 3'b000;
            end
        end else begin
            strb_q[0] <= {per_img_vsync, per_img_href, per_img_de};
            for (int i = 1; i < 5; i++) begin
                strb_q[i] <= strb_q[i-1];
            end
        end
    end

    assign post_img_vsync = strb_q[4][2];
    assign post_img_href  = strb_q[4][1];
    assign post_img_de    = strb_q[4][0];

    // ------------------------------------------------------- rank pipeline
    pix_t       win_q [3][3];
    pix_t       s1_center, s2_center, s3_center, s4_center;
    logic       s1_pass, s2_pass, s3_pass;
    logic [1:0] s1_mode, s2_mode, s3_mode;
    pix_t       s2_hi [3];
    pix_t       s2_mid [3];
    pix_t       s2_lo [3];
    pix_t       s3_a, s3_b, s3_c, s3_mn, s3_mx;
    pix_t       s4_d, s4_q;

    // Window rows hold r-2, r-1, r; column 2 is the newest pixel
    always_ff @(posedge clk) begin
        if (per_img_de) begin
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= win_q[i][2];
            end
            win_q[0][2] <= lb2_rd;
            win_q[1][2] <= lb1_rd;
            win_q[2][2] <= per_img_gray;
        end
        s1_center <= per_img_gray;
        s1_pass   <= ~win_full;
        s1_mode   <= mode_active;

        for (int i = 0; i < 3; i++) begin
            s2_hi[i]  <= max3(win_q[i][0], win_q[i][1], win_q[i][2]);
            s2_mid[i] <= med3(win_q[i][0], win_q[i][1], win_q[i][2]);
            s2_lo[i]  <= min3(win_q[i][0], win_q[i][1], win_q[i][2]);
        end
        s2_center <= s1_center;
        s2_pass   <= s1_pass;
        s2_mode   <= s1_mode;

        // With rows sorted, median-of-9 = med(min of highs, med of mids, max of lows)
        s3_a      <= min3(s2_hi[0], s2_hi[1], s2_hi[2]);
        s3_b      <= med3(s2_mid[0], s2_mid[1], s2_mid[2]);
        s3_c      <= max3(s2_lo[0], s2_lo[1], s2_lo[2]);
        s3_mn     <= min3(s2_lo[0], s2_lo[1], s2_lo[2]);
        s3_mx     <= max3(s2_hi[0], s2_hi[1], s2_hi[2]);
        s3_center <= s2_center;
        s3_pass   <= s2_pass;
        s3_mode   <= s2_mode;

        s4_q      <= s4_d;
        s4_center <= s3_center;
    end

    always_comb begin
        s4_d = s3_center;
        if (!s3_pass) begin
            case (s3_mode)
                2'b01:   s4_d = med3(s3_a, s3_b, s3_c);
                2'b10:   s4_d = s3_mn;
                2'b11:   s4_d = s3_mx;
                default: s4_d = s3_center;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            post_img_gray <= '0;
        end else if (strb_q[3][0]) begin
            post_img_gray <= s4_q;
        end
    end

`ifdef RANK_FILTER_STATS_EN
    logic [31:0] cnt_q;
    logic        post_vs_q;
    pix_t        post_center_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            post_vs_q     <= 1'b0;
            post_center_q <= '0;
            changed_cnt   <= '0;
        end else begin
            post_vs_q <= post_img_vsync;
            if (strb_q[3][0]) begin
                post_center_q <= s4_center;
            end
            if (post_img_vsync && !post_vs_q) begin
                cnt_q <= '0;
            end else if (post_img_de && post_img_gray != post_center_q) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (!post_img_vsync && post_vs_q) begin
                changed_cnt <= cnt_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rank_filter_3x3.sv
// Directed bench for rank_filter_3x3: table of frame-level vectors plus mode-toggle and
// mid-frame reset sequences; built with a short line buffer so overflow columns are exercised.
module tb_rank_filter_3x3;

    localparam int LM = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] filter_mode;
    logic       per_img_vsync, per_img_href, per_img_de;
    logic [7:0] per_img_gray;
    logic       post_img_vsync, post_img_href, post_img_de;
    logic [7:0] post_img_gray;
    logic [1:0] mode_active;
`ifdef RANK_FILTER_STATS_EN
    logic [31:0] changed_cnt;
`endif

    rank_filter_3x3 #(
        .DATA_W   (8),
        .LINE_MAX (LM)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .filter_mode    (filter_mode),
        .per_img_vsync  (per_img_vsync),
        .per_img_href   (per_img_href),
        .per_img_de     (per_img_de),
        .per_img_gray   (per_img_gray),
        .post_img_vsync (post_img_vsync),
        .post_img_href  (post_img_href),
        .post_img_de    (post_img_de),
        .post_img_gray  (post_img_gray),
`ifdef RANK_FILTER_STATS_EN
        .changed_cnt    (changed_cnt),
`endif
        .mode_active    (mode_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;     // 0 impulse at (4,4), 1 ramp c+8r
        logic [1:0] mode;
        int         width;
        int         height;
        int         off;      // ramp: expected = input - off for complete windows
        int         hot_lo;   // impulse: square region of 0xFF outputs
        int         hot_hi;
        int         exp_cnt;
        bit         toggle;   // switch filter_mode to 11 mid-frame
    } vec_t;

    vec_t       vecs [8];
    int         nvec = 0;
    int         nfail = 0;
    bit         lat_chk = 1'b0;
    logic [2:0] hist [6];
    logic [7:0] out_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int kind, input int r, input int c);
        if (kind == 0) return (r == 4 && c == 4) ? 8'hFF : 8'h40;
        return 8'(c + 8 * r);
    endfunction

    function automatic logic [7:0] exp_val(input vec_t v, input int r, input int c);
        logic [7:0] in;
        in = pix_val(v.kind, r, c);
        if (c >= LM || r < 2 || c < 2 || v.mode == 2'b00) return in;
        if (v.kind == 0) begin
            if (r >= v.hot_lo && r <= v.hot_hi && c >= v.hot_lo && c <= v.hot_hi) return 8'hFF;
            return 8'h40;
        end
        return in - 8'(v.off);
    endfunction

    // Strobe latency reference and output capture, sampled on the falling edge
    always @(negedge clk) begin
        for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {per_img_vsync, per_img_href, per_img_de};
        if (lat_chk) check("strobe_latency", {29'd0, post_img_vsync, post_img_href, post_img_de},
                           {29'd0, hist[5]});
        if (post_img_de) out_q.push_back(post_img_gray);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int vi);
        vec_t       v;
        logic [7:0] e;
        v = vecs[vi];
        out_q.delete();
        filter_mode   = v.mode;
        per_img_vsync = 1'b1;
        tick();
        check($sformatf("mode_latch v%0d", vi), {30'd0, mode_active}, {30'd0, v.mode});
        tick();
        for (int r = 0; r < v.height; r++) begin
            if (v.toggle && r == 3) filter_mode = 2'b11;
            if (v.toggle && r == 5) check("mode_hold", {30'd0, mode_active}, 32'd1);
            per_img_href = 1'b1;
            for (int c = 0; c < v.width; c++) begin
                per_img_de   = 1'b1;
                per_img_gray = pix_val(v.kind, r, c);
                tick();
            end
            per_img_de   = 1'b0;
            per_img_href = 1'b0;
            repeat (3) tick();
        end
        repeat (2) tick();
        per_img_vsync = 1'b0;
        repeat (10) tick();
        if (v.toggle) check("mode_hold_end", {30'd0, mode_active}, 32'd1);
        check($sformatf("out_count v%0d", vi), out_q.size(), v.width * v.height);
        for (int r = 0; r < v.height; r++) begin
            for (int c = 0; c < v.width; c++) begin
                if (r * v.width + c < out_q.size()) begin
                    check($sformatf("pix v%0d r%0d c%0d", vi, r, c),
                          {24'd0, out_q[r * v.width + c]}, {24'd0, exp_val(v, r, c)});
                end
            end
        end
        e = exp_val(v, v.height - 1, v.width - 1);
        check($sformatf("gray_hold v%0d", vi), {24'd0, post_img_gray}, {24'd0, e});
`ifdef RANK_FILTER_STATS_EN
        check($sformatf("changed_cnt v%0d", vi), changed_cnt, v.exp_cnt);
`endif
    endtask

    initial begin
        //          kind mode   w   h   off lo hi cnt toggle
        vecs[0] = '{0, 2'b01, 8,  8,  0,  1, 0, 1,  1'b1};
        vecs[1] = '{0, 2'b11, 8,  8,  0,  4, 6, 8,  1'b0};
        vecs[2] = '{0, 2'b10, 8,  8,  0,  1, 0, 1,  1'b0};
        vecs[3] = '{1, 2'b00, 8,  8,  0,  1, 0, 0,  1'b0};
        vecs[4] = '{1, 2'b01, 8,  8,  9,  1, 0, 36, 1'b0};
        vecs[5] = '{1, 2'b10, 8,  8,  18, 1, 0, 36, 1'b0};
        vecs[6] = '{1, 2'b11, 8,  8,  0,  1, 0, 0,  1'b0};
        vecs[7] = '{1, 2'b01, 12, 8,  9,  1, 0, 36, 1'b0};
        for (int i = 0; i < 6; i++) hist[i] = 3'b000;

        rst           = 1'b1;
        filter_mode   = 2'b10;
        per_img_vsync = 1'b0;
        per_img_href  = 1'b0;
        per_img_de    = 1'b0;
        per_img_gray  = 8'h00;
        repeat (3) tick();
        check("rst_strobes", {29'd0, post_img_vsync, post_img_href, post_img_de}, 32'd0);
        check("rst_gray", {24'd0, post_img_gray}, 32'd0);
        check("rst_mode", {30'd0, mode_active}, 32'd1);
        rst = 1'b0;
        repeat (2) tick();
        check("idle_mode", {30'd0, mode_active}, 32'd1);
        lat_chk = 1'b1;

        for (int i = 0; i < 8; i++) send_frame(i);

        // Mid-frame reset: the running max-mode frame is discarded
        lat_chk       = 1'b0;
        filter_mode   = 2'b11;
        per_img_vsync = 1'b1;
        repeat (2) tick();
        for (int r = 0; r < 6; r++) begin
            per_img_href = 1'b1;
            for (int c = 0; c < 8; c++) begin
                per_img_de   = 1'b1;
                per_img_gray = pix_val(1, r, c);
                if (r == 3 && c == 4) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    check("midrst_strobes",
                          {29'd0, post_img_vsync, post_img_href, post_img_de}, 32'd0);
                    check("midrst_gray", {24'd0, post_img_gray}, 32'd0);
                    check("midrst_mode", {30'd0, mode_active}, 32'd1);
                end else begin
                    tick();
                end
            end
            per_img_de   = 1'b0;
            per_img_href = 1'b0;
            repeat (3) tick();
        end
        per_img_vsync = 1'b0;
        repeat (10) tick();
        lat_chk = 1'b1;
        send_frame(1);
        send_frame(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
